// File: rtl/win_scan_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// win_scan_engine : latches a board and scans every K-in-a-row line, one per clk
// Define WIN_SCAN_ALL_EN for a full scan plus oWinCount.   Rev 1.0
// ---------------------------------------------------------------------------
module win_scan_engine #(
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int K     = 3,
    parameter int SYM_W = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            iStart,
    input  logic [ROWS*COLS*SYM_W-1:0]      iBoard,
    output logic                            oBusy,
    output logic                            oDone,
    output logic                            oWinFlag,
    output logic [SYM_W-1:0]                oWinSym,
    output logic [$clog2(ROWS*COLS)-1:0]    oWinPos,
    output logic [1:0]                      oWinDir
`ifdef WIN_SCAN_ALL_EN
    ,
    output logic [$clog2(4*ROWS*COLS+1)-1:0] oWinCount
`endif
);

    localparam int N     = ROWS * COLS;
    localparam int POS_W = $clog2(N);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [N*SYM_W-1:0]     board_q, board_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [1:0]             dir_q, dir_d;
    logic                   flag_q, flag_d;
    logic [SYM_W-1:0]       sym_q, sym_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic [1:0]             wdir_q, wdir_d;
`ifdef WIN_SCAN_ALL_EN
    localparam int CNT_W = $clog2(4*N+1);
    logic [CNT_W-1:0]       count_q, count_d;
`endif

    logic [SYM_W-1:0]       cells [N];
    logic                   cand_win;
    logic                   on_board;
    logic                   last_cand;
    logic [SYM_W-1:0]       cand_sym;
    logic [POS_W-1:0]       cand_pos;
    int                     r0, c0, rr, cc, dr, dc;

    for (genvar i = 0; i < N; i++) begin : g_cells
        assign cells[i] = board_q[i*SYM_W +: SYM_W];
    end

    // Start cell is always on the board; only the far end of the run can fall off.
    always_comb begin
        r0       = int'(row_q);
        c0       = int'(col_q);
        dr       = (dir_q == 2'd0) ? 0 : 1;
        dc       = (dir_q == 2'd1) ? 0 : ((dir_q == 2'd3) ? -1 : 1);
        on_board = (r0 + dr*(K-1) < ROWS) && (c0 + dc*(K-1) < COLS) &&
                   (c0 + dc*(K-1) >= 0);
        cand_pos = POS_W'(r0*COLS + c0);
        cand_sym = cells[cand_pos];
        cand_win = on_board && (cand_sym != '0);
        rr       = 0;
        cc       = 0;
        for (int j = 1; j < K; j++) begin
            rr = on_board ? (r0 + dr*j) : 0;
            cc = on_board ? (c0 + dc*j) : 0;
            if (cells[POS_W'(rr*COLS + cc)] != cand_sym) begin
                cand_win = 1'b0;
            end
        end
    end

    assign last_cand = (dir_q == 2'd3) && (row_q == ROW_W'(ROWS-1)) &&
                       (col_q == COL_W'(COLS-1));

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        row_d   = row_q;
        col_d   = col_q;
        dir_d   = dir_q;
        flag_d  = flag_q;
        sym_d   = sym_q;
        pos_d   = pos_q;
        wdir_d  = wdir_q;
`ifdef WIN_SCAN_ALL_EN
        count_d = count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_SCAN;
                    board_d = iBoard;
                    row_d   = '0;
                    col_d   = '0;
                    dir_d   = '0;
                    flag_d  = 1'b0;
                    sym_d   = '0;
                    pos_d   = '0;
                    wdir_d  = '0;
`ifdef WIN_SCAN_ALL_EN
                    count_d = '0;
`endif
                end
            end
            ST_SCAN: begin
                if (col_q == COL_W'(COLS-1)) begin
                    col_d = '0;
                    if (row_q == ROW_W'(ROWS-1)) begin
                        row_d = '0;
                        dir_d = dir_q + 2'd1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
                // Only the lowest-index win is recorded.
                if (cand_win && !flag_q) begin
                    flag_d = 1'b1;
                    sym_d  = cand_sym;
                    pos_d  = cand_pos;
                    wdir_d = dir_q;
                end
`ifdef WIN_SCAN_ALL_EN
                if (cand_win) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (last_cand) begin
                    state_d = ST_DONE;
                end
`else
                if (cand_win || last_cand) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            board_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            dir_q   <= '0;
            flag_q  <= 1'b0;
            sym_q   <= '0;
            pos_q   <= '0;
            wdir_q  <= '0;
`ifdef WIN_SCAN_ALL_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dir_q   <= dir_d;
            flag_q  <= flag_d;
            sym_q   <= sym_d;
            pos_q   <= pos_d;
            wdir_q  <= wdir_d;
`ifdef WIN_SCAN_ALL_EN
            count_q <= count_d;
`endif
        end
    end

    assign oBusy    = (state_q != ST_IDLE);
    assign oDone    = (state_q == ST_DONE);
    assign oWinFlag = flag_q;
    assign oWinSym  = sym_q;
    assign oWinPos  = pos_q;
    assign oWinDir  = wdir_q;
`ifdef WIN_SCAN_ALL_EN
    assign oWinCount = count_q;
`endif

endmodule
`default_nettype wire
